// File: rtl/trackball_decoder.sv
`timescale 1ns/1ps
// trackball_decoder
//   Game-side decoder for the mouse-to-trackball encoder. Each axis delivers a
//   direction level and a clock level whose every change is one step. Steps
//   are accumulated into two wrapping up/down counters. The CPU reads
//   snapshots of the counters in the IN0/IN1 trackball layout.
//
//   Optional build macro: TRACKBALL_DECODER_FILTER_EN
//     When it is defined, a glitch filter sits after each synchronized clk
//     bit. The filtered level only follows the synced level once the two have
//     differed for FILT_LEN consecutive cycles.
//
// Parameters
//   CNT_W     counter width per axis (1..7)
//   FILT_LEN  glitch-filter stability length in cycles (2..15), filter build only
//
// Ports
//   clk_12mhz  core clock, rising edge
//   reset_n    asynchronous active-low reset
//   trak_i     {x_dir, x_clk, y_dir, y_clk}, asynchronous to clk_12mhz
//   flip_i     cocktail flip, inverts both direction bits
//   pause_i    1 = steps discarded
//   rd_x_i     snapshot strobe for X
//   rd_y_i     snapshot strobe for Y
//   clr_i      clear both counters
//   x_o, y_o   {dir_eff, zeros, cnt} snapshots

module trackball_decoder #(
  parameter int CNT_W    = 4,
  parameter int FILT_LEN = 3
) (
  input  logic       clk_12mhz,
  input  logic       reset_n,
  input  logic [3:0] trak_i,
  input  logic       flip_i,
  input  logic       pause_i,
  input  logic       rd_x_i,
  input  logic       rd_y_i,
  input  logic       clr_i,
  output logic [7:0] x_o,
  output logic [7:0] y_o
);

  // Elaboration-time parameter range checks.
  if (CNT_W < 1 || CNT_W > 7) begin : g_bad_cnt_w
    $error("trackball_decoder: CNT_W must be 1..7");
  end
  if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_filt_len
    $error("trackball_decoder: FILT_LEN must be 2..15");
  end

  // ---------------------------------------------------------------------------
  // Startup guard: no step detection until three cycles after reset release.
  // Without it, a clk line that is already high at release would look like an
  // edge against the zero-reset history.
  // ---------------------------------------------------------------------------
  typedef enum logic {GUARD, RUN} guard_state_e;

  guard_state_e state_q, state_d;
  logic [1:0]   guard_cnt_q, guard_cnt_d;

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= GUARD;
      guard_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      guard_cnt_q <= guard_cnt_d;
    end
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    state_d     = state_q;
    guard_cnt_d = guard_cnt_q;
    case (state_q)
      GUARD: begin
        if (guard_cnt_q == 2'd2) begin
          state_d     = RUN;
          guard_cnt_d = 2'd0;
        end else begin
          guard_cnt_d = guard_cnt_q + 2'd1;
        end
      end
      default: ;  // RUN is terminal until reset
    endcase
  end

  // ---------------------------------------------------------------------------
  // Input synchronizers. Both bits of an axis come from one encoder register,
  // so dir and clk stay coherent through the same flop stages.
  // ---------------------------------------------------------------------------
  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 4'h0;
      sync2_q <= 4'h0;
    end else begin
      // NOTE: non-blocking, so sync2_q takes the old sync1_q and both stages stay distinct flops.
      sync1_q <= trak_i;
      sync2_q <= sync1_q;
    end
  end

  // Index 1 = X, index 0 = Y throughout.
  logic [1:0] raw_lvl, clk_lvl, prev_q, step, dir_eff;

  assign raw_lvl = {sync2_q[2], sync2_q[0]};
  assign dir_eff = {sync2_q[3], sync2_q[1]} ^ {2{flip_i}};

`ifdef TRACKBALL_DECODER_FILTER_EN
  logic [1:0]      filt_q;
  logic [1:0][3:0] stab_q;

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 2'b00;
      stab_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw_lvl[i] != filt_q[i]) begin
          // This is the FILT_LEN-th consecutive differing cycle.
          if (stab_q[i] == 4'(FILT_LEN - 1)) begin
            filt_q[i] <= raw_lvl[i];
            stab_q[i] <= 4'd0;
          end else begin
            stab_q[i] <= stab_q[i] + 4'd1;
          end
        end else begin
          stab_q[i] <= 4'd0;
        end
      end
    end
  end

  assign clk_lvl = filt_q;
`else
  assign clk_lvl = raw_lvl;
`endif

  // Edge history always tracks the level, even while guarded or paused. A
  // discarded step is therefore gone for good and cannot burst out later.
  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) prev_q <= 2'b00;
    else          prev_q <= clk_lvl;
  end

  assign step = (clk_lvl ^ prev_q) & {2{state_q == RUN}};

  // ---------------------------------------------------------------------------
  // Counters and snapshots. Snapshots sample the pre-update counts, so a read
  // that coincides with a step or a clear returns the old value.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_x_q, cnt_y_q;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt,
                                            input logic up);
    return up ? cnt + CNT_W'(1) : cnt - CNT_W'(1);
  endfunction

  function automatic logic [7:0] snap(input logic dir, input logic [CNT_W-1:0] cnt);
    logic [7:0] s;
    s            = 8'h00;
    s[CNT_W-1:0] = cnt;
    s[7]         = dir;
    return s;
  endfunction

  always_ff @(posedge clk_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      cnt_x_q <= '0;
      cnt_y_q <= '0;
      x_o     <= 8'h00;
      y_o     <= 8'h00;
    end else begin
      if (clr_i) begin
        cnt_x_q <= '0;
        cnt_y_q <= '0;
      end else if (!pause_i) begin
        if (step[1]) cnt_x_q <= bump(cnt_x_q, dir_eff[1]);
        if (step[0]) cnt_y_q <= bump(cnt_y_q, dir_eff[0]);
      end
      if (rd_x_i) x_o <= snap(dir_eff[1], cnt_x_q);
      if (rd_y_i) y_o <= snap(dir_eff[0], cnt_y_q);
    end
  end

endmodule

// File: tb/tb_trackball_decoder.sv
`timescale 1ns/1ps
// tb_trackball_decoder
//   Directed and randomized stimulus for trackball_decoder in its default
//   (unfiltered) build. The reference model treats the decoder as a black
//   box. The trak_i value applied before edge t becomes visible two edges
//   later. A step lands at edge t when that delayed clk level changed from
//   the cycle before. Edges 1..3 after reset release are ignored.

module tb_trackball_decoder;
  localparam int CNT_W    = 4;
  localparam int FILT_LEN = 3;
  localparam int M        = 1 << CNT_W;

  logic       clk_12mhz = 1'b0;
  logic       reset_n   = 1'b0;
  logic [3:0] trak_i    = 4'h0;
  logic       flip_i    = 1'b0;
  logic       pause_i   = 1'b0;
  logic       rd_x_i    = 1'b0;
  logic       rd_y_i    = 1'b0;
  logic       clr_i     = 1'b0;
  logic [7:0] x_o, y_o;

  trackball_decoder #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) dut (
    .clk_12mhz (clk_12mhz),
    .reset_n   (reset_n),
    .trak_i    (trak_i),
    .flip_i    (flip_i),
    .pause_i   (pause_i),
    .rd_x_i    (rd_x_i),
    .rd_y_i    (rd_y_i),
    .clr_i     (clr_i),
    .x_o       (x_o),
    .y_o       (y_o)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [3:0] d1, d2, d3;      // trak_i applied 1, 2 and 3 edges ago
  int         t;               // edges since reset release
  int         cnt_x, cnt_y;
  logic [7:0] exp_x, exp_y;

  // Current drive levels
  logic xd, xc, yd, yc;
  logic cur_fl, cur_pa;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mk(input logic dir, input int cnt);
    return {dir, 7'(cnt)};
  endfunction

  // One clock cycle: drive inputs, advance the model to the coming edge,
  // then compare both outputs just after the edge.
  task automatic cyc(input logic rx, input logic ry, input logic cl, input string tag);
    logic [3:0] tr;
    tr      = {xd, xc, yd, yc};
    trak_i  = tr;
    flip_i  = cur_fl;
    pause_i = cur_pa;
    rd_x_i  = rx;
    rd_y_i  = ry;
    clr_i   = cl;
    t++;
    if (rx) exp_x = mk(d2[3] ^ cur_fl, cnt_x);
    if (ry) exp_y = mk(d2[1] ^ cur_fl, cnt_y);
    if (cl) begin
      cnt_x = 0;
      cnt_y = 0;
    end else if (!cur_pa && t >= 4) begin
      if (d2[2] != d3[2]) cnt_x = (cnt_x + ((d2[3] ^ cur_fl) ? 1 : M - 1)) % M;
      if (d2[0] != d3[0]) cnt_y = (cnt_y + ((d2[1] ^ cur_fl) ? 1 : M - 1)) % M;
    end
    d3 = d2;
    d2 = d1;
    d1 = tr;
    @(posedge clk_12mhz);
    #1;
    check({tag, "_x"}, x_o, exp_x);
    check({tag, "_y"}, y_o, exp_y);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, tag);
  endtask

  // Assert reset away from a clock edge, confirm it clears the outputs
  // asynchronously, and release it between edges.
  task automatic do_reset(input logic [3:0] tr);
    reset_n = 1'b0;
    {xd, xc, yd, yc} = tr;
    trak_i = tr;
    rd_x_i = 1'b0;
    rd_y_i = 1'b0;
    clr_i  = 1'b0;
    #2;
    check("rst_async_x", x_o, 8'h00);
    check("rst_async_y", y_o, 8'h00);
    repeat (2) @(posedge clk_12mhz);
    @(negedge clk_12mhz);
    check("rst_hold_x", x_o, 8'h00);
    check("rst_hold_y", y_o, 8'h00);
    d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
    t = 0;
    cnt_x = 0; cnt_y = 0;
    exp_x = 8'h00; exp_y = 8'h00;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    cur_fl = 1'b0;
    cur_pa = 1'b0;
    #3;

    // Startup with both clk lines already high: no spurious step.
    cur_fl = 1'b1;
    do_reset(4'b0101);
    idle(10, "start");
    cyc(1'b1, 1'b1, 1'b0, "start_rd");
    check("tp_start_x", x_o, 8'h80);
    check("tp_start_y", y_o, 8'h80);
    cur_fl = 1'b0;

    // Five up-steps, then seven down-steps wrapping below zero.
    xd = 1'b1;
    for (int i = 0; i < 5; i++) begin xc = ~xc; cyc(1'b0, 1'b0, 1'b0, "up"); end
    idle(3, "up_wait");
    cyc(1'b1, 1'b0, 1'b0, "up_rd");
    check("tp_x85", x_o, 8'h85);
    xd = 1'b0;
    for (int i = 0; i < 7; i++) begin xc = ~xc; cyc(1'b0, 1'b0, 1'b0, "dn"); end
    idle(3, "dn_wait");
    cyc(1'b1, 1'b0, 1'b0, "dn_rd");
    check("tp_x0e", x_o, 8'h0E);

    // Flip inverts direction: three "up" y steps count down from 0.
    cur_fl = 1'b1;
    yd = 1'b1;
    for (int i = 0; i < 3; i++) begin yc = ~yc; cyc(1'b0, 1'b0, 1'b0, "flip"); end
    idle(3, "flip_wait");
    cyc(1'b0, 1'b1, 1'b0, "flip_rd");
    check("tp_y0d", y_o, 8'h0D);
    cur_fl = 1'b0;

    // Clear lands on the same edge as an x step: clear wins.
    xd = 1'b1;
    xc = ~xc;
    cyc(1'b0, 1'b0, 1'b0, "clr_tog");
    idle(1, "clr_gap");
    cyc(1'b0, 1'b0, 1'b1, "clr_hit");
    cyc(1'b1, 1'b0, 1'b0, "clr_rd");
    check("tp_clr", x_o, 8'h80);

    // Read lands on the same edge as a step from 2: pre-update count.
    for (int i = 0; i < 2; i++) begin xc = ~xc; cyc(1'b0, 1'b0, 1'b0, "rds_pre"); end
    idle(3, "rds_wait");
    xc = ~xc;
    cyc(1'b0, 1'b0, 1'b0, "rds_tog");
    idle(1, "rds_gap");
    cyc(1'b1, 1'b0, 1'b0, "rds_hit");
    check("tp_rd_pre", x_o, 8'h82);
    cyc(1'b1, 1'b0, 1'b0, "rds_next");
    check("tp_rd_post", x_o, 8'h83);

    // Steps during pause are discarded; no burst after unpause.
    cur_pa = 1'b1;
    for (int i = 0; i < 4; i++) begin xc = ~xc; cyc(1'b0, 1'b0, 1'b0, "pause"); end
    idle(3, "pause_wait");
    cur_pa = 1'b0;
    idle(5, "unpause");
    cyc(1'b1, 1'b0, 1'b0, "pause_rd");
    check("tp_pause", x_o, 8'h83);

    // Randomized traffic, with one reset landing mid-operation.
    for (int i = 0; i < 600; i++) begin
      logic rx, ry, cl;
      if (i == 300) do_reset(4'($urandom));
      {xd, xc, yd, yc} = 4'($urandom);
      if ($urandom_range(0, 15) == 0) cur_fl = ~cur_fl;
      cur_pa = ($urandom_range(0, 7) == 0);
      rx = 1'($urandom);
      ry = 1'($urandom);
      cl = ($urandom_range(0, 15) == 0);
      cyc(rx, ry, cl, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
